// File: rtl/uart_rx_pkg.sv
// Shared UART RX definitions: legal prescale ratios, idle line level,
// sampler state encoding and the 2-of-3 vote used by the bit sampler.
package uart_rx_pkg;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  localparam logic RX_IDLE_LEVEL = 1'b1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } sampler_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_bit_sampler_if.sv
// Handshake/data bundle between the RX FSM (master) and the bit sampler (slave).
interface rx_bit_sampler_if #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
);

  logic                  i_enable;
  logic [PRESCALE_W-1:0] i_prescale;
  logic                  i_rx_in;
  logic [PRESCALE_W-1:0] o_edge_cnt;
  logic [BIT_CNT_W-1:0]  o_bit_cnt;
  logic                  o_bit_done;
  logic                  o_sampled_bit;
  logic                  o_sample_valid;

  modport master (
    output i_enable, i_prescale, i_rx_in,
    input  o_edge_cnt, o_bit_cnt, o_bit_done, o_sampled_bit, o_sample_valid
  );

  modport slave (
    input  i_enable, i_prescale, i_rx_in,
    output o_edge_cnt, o_bit_cnt, o_bit_done, o_sampled_bit, o_sample_valid
  );

endinterface

// File: rtl/rx_edge_bit_counter.sv
// Oversampling edge counter and saturating bit index; the prescale ratio is
// legalised and latched at the start of each bit period.
module rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic [PRESCALE_W-1:0] o_edge_cnt,
  output logic [BIT_CNT_W-1:0]  o_bit_cnt,
  output logic                  o_bit_done,
  output logic [PRESCALE_W-1:0] o_prescale
);

  sampler_state_e        state_q, state_d;
  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] prescale_eff;
  logic                  last_edge;

  function automatic logic [PRESCALE_W-1:0] legal_prescale(input logic [PRESCALE_W-1:0] raw);
    if (raw == PRESCALE_W'(PRESCALE_16) || raw == PRESCALE_W'(PRESCALE_32)) begin
      return raw;
    end
    return PRESCALE_W'(PRESCALE_8);
  endfunction

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      prescale_q <= PRESCALE_W'(PRESCALE_8);
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      prescale_q <= prescale_d;
    end
  end

  // The ratio only follows i_prescale at a bit boundary; mid-bit it is frozen.
  always_comb begin
    prescale_eff = prescale_q;
    if (edge_cnt_q == '0 || state_q == S_IDLE) begin
      prescale_eff = legal_prescale(i_prescale);
    end
    prescale_d = prescale_eff;
    last_edge  = (edge_cnt_q == prescale_eff - PRESCALE_W'(1));

    state_d    = i_enable ? S_COUNT : S_IDLE;
    edge_cnt_d = '0;
    bit_cnt_d  = '0;

    case (state_d)
      S_COUNT: begin
        bit_cnt_d = bit_cnt_q;
        if (last_edge) begin
          edge_cnt_d = '0;
          if (bit_cnt_q != '1) begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end else begin
          edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
        end
      end
      default: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase
  end

  assign o_edge_cnt = edge_cnt_q;
  assign o_bit_cnt  = bit_cnt_q;
  assign o_bit_done = i_enable && last_edge;
  assign o_prescale = prescale_eff;

endmodule

// File: rtl/rx_bit_sampler.sv
// UART RX bit sampler: three mid-bit samples majority-voted into one bit with a
// one-cycle valid strobe. Define RX_SYNC_EN to add a 2-flop line synchronizer.
module rx_bit_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  rx_bit_sampler_if.slave   bus
);

  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  bit_done;
  logic [PRESCALE_W-1:0] prescale_eff;
  logic [PRESCALE_W-1:0] half;
  logic                  rx_line;

  logic s0_q, s0_d;
  logic s1_q, s1_d;
  logic sampled_bit_q, sampled_bit_d;
  logic sample_valid_q, sample_valid_d;

  rx_edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_CNT_W  (BIT_CNT_W)
  ) u_counter (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_enable   (bus.i_enable),
    .i_prescale (bus.i_prescale),
    .o_edge_cnt (edge_cnt),
    .o_bit_cnt  (bit_cnt),
    .o_bit_done (bit_done),
    .o_prescale (prescale_eff)
  );

`ifdef RX_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = bus.i_rx_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync1_q <= RX_IDLE_LEVEL;
      sync2_q <= RX_IDLE_LEVEL;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign rx_line = sync2_q;
`else
  assign rx_line = bus.i_rx_in;
`endif

  // Samples at h-1, h, and the vote at h+1 so the strobe is visible at h+2.
  always_comb begin
    half           = prescale_eff >> 1;
    s0_d           = s0_q;
    s1_d           = s1_q;
    sampled_bit_d  = sampled_bit_q;
    sample_valid_d = 1'b0;
    if (bus.i_enable) begin
      if (edge_cnt == half - PRESCALE_W'(1)) begin
        s0_d = rx_line;
      end
      if (edge_cnt == half) begin
        s1_d = rx_line;
      end
      if (edge_cnt == half + PRESCALE_W'(1)) begin
        sampled_bit_d  = majority3(s0_q, s1_q, rx_line);
        sample_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      s0_q           <= RX_IDLE_LEVEL;
      s1_q           <= RX_IDLE_LEVEL;
      sampled_bit_q  <= RX_IDLE_LEVEL;
      sample_valid_q <= 1'b0;
    end else begin
      s0_q           <= s0_d;
      s1_q           <= s1_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign bus.o_edge_cnt     = edge_cnt;
  assign bus.o_bit_cnt      = bit_cnt;
  assign bus.o_bit_done     = bit_done;
  assign bus.o_sampled_bit  = sampled_bit_q;
  assign bus.o_sample_valid = sample_valid_q;

endmodule

// File: tb/tb_rx_bit_sampler.sv
// Directed self-checking bench for rx_bit_sampler; line stimulus is advanced
// by two cycles when RX_SYNC_EN is defined so sample points stay aligned.
module tb_rx_bit_sampler;

`ifdef RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic i_clk;
  logic i_reset;
  int   tests_run;
  int   tests_failed;

  rx_bit_sampler_if #(.PRESCALE_W(6), .BIT_CNT_W(4)) bus ();

  rx_bit_sampler #(.PRESCALE_W(6), .BIT_CNT_W(4)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic enable, input logic [5:0] prescale, input logic rx);
    bus.i_enable   = enable;
    bus.i_prescale = prescale;
    bus.i_rx_in    = rx;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_edge_cnt"}, 32'(bus.o_edge_cnt), 0);
    checkOutput({tag, "_bit_cnt"}, 32'(bus.o_bit_cnt), 0);
    checkOutput({tag, "_sampled_bit"}, 32'(bus.o_sampled_bit), 1);
    checkOutput({tag, "_sample_valid"}, 32'(bus.o_sample_valid), 0);
    checkOutput({tag, "_bit_done"}, 32'(bus.o_bit_done), 0);
  endtask

  // One full enabled bit period; zero_mask bit x set means the line is 0 at edge x.
  task automatic runBit(input int p, input logic [5:0] ps_start, input logic [5:0] ps_mid,
                        input logic [31:0] zero_mask, input int bit_idx,
                        input logic old_bit, input logic new_bit);
    logic [5:0] ps;
    int         idx;
    for (int e = 0; e < p; e++) begin
      ps  = (e >= 3 && e < p - 2) ? ps_mid : ps_start;
      idx = (e + LAT) % p;
      applyStimulus(1'b1, ps, zero_mask[idx] ? 1'b0 : 1'b1);
      checkOutput("edge_cnt", 32'(bus.o_edge_cnt), e);
      checkOutput("bit_cnt", 32'(bus.o_bit_cnt), bit_idx);
      checkOutput("sample_valid", 32'(bus.o_sample_valid), 32'(e == p / 2 + 2));
      checkOutput("bit_done", 32'(bus.o_bit_done), 32'(e == p - 1));
      checkOutput("sampled_bit", 32'(bus.o_sampled_bit), (e >= p / 2 + 2) ? 32'(new_bit) : 32'(old_bit));
      tick();
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    i_reset      = 1'b0;
    applyStimulus(1'b0, 6'd8, 1'b0);
    tick();
    tick();
    checkReset("reset");

    // Constant-low line at p=8: vote strobes at edge 6 in each bit.
    i_reset = 1'b1;
    runBit(8, 6'd8, 6'd8, 32'hFFFF_FFFF, 0, 1'b1, 1'b0);
    runBit(8, 6'd8, 6'd8, 32'hFFFF_FFFF, 1, 1'b0, 1'b0);

    // p=16 with a mid-bit prescale change that must be ignored.
    runBit(16, 6'd16, 6'd8, 32'h0000_0100, 2, 1'b0, 1'b1);
    runBit(16, 6'd16, 6'd8, 32'h0000_0300, 3, 1'b1, 1'b0);

    // Illegal prescale 12 behaves as 8.
    runBit(8, 6'd12, 6'd12, 32'h0000_0000, 4, 1'b0, 1'b1);

    // Enable drops at edge 4: no strobe, counters clear, bit held.
    for (int e = 0; e < 4; e++) begin
      applyStimulus(1'b1, 6'd8, 1'b0);
      checkOutput("abort_edge_cnt", 32'(bus.o_edge_cnt), e);
      checkOutput("abort_bit_cnt", 32'(bus.o_bit_cnt), 5);
      tick();
    end
    applyStimulus(1'b0, 6'd8, 1'b0);
    checkOutput("abort_edge4", 32'(bus.o_edge_cnt), 4);
    checkOutput("abort_bit_done", 32'(bus.o_bit_done), 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput("idle_edge_cnt", 32'(bus.o_edge_cnt), 0);
      checkOutput("idle_bit_cnt", 32'(bus.o_bit_cnt), 0);
      checkOutput("idle_sample_valid", 32'(bus.o_sample_valid), 0);
      checkOutput("idle_sampled_bit", 32'(bus.o_sampled_bit), 1);
    end

    // Twenty bit periods: bit_cnt saturates at 15.
    for (int b = 0; b < 20; b++) begin
      runBit(8, 6'd8, 6'd8, 32'hFFFF_FFFF, (b > 15) ? 15 : b, (b == 0) ? 1'b1 : 1'b0, 1'b0);
    end

    // Async reset in bit 3 while the valid strobe is high.
    applyStimulus(1'b0, 6'd8, 1'b0);
    tick();
    checkOutput("restart_bit_cnt", 32'(bus.o_bit_cnt), 0);
    for (int b = 0; b < 3; b++) begin
      runBit(8, 6'd8, 6'd8, 32'hFFFF_FFFF, b, 1'b0, 1'b0);
    end
    for (int e = 0; e < 6; e++) begin
      applyStimulus(1'b1, 6'd8, 1'b0);
      tick();
    end
    checkOutput("pre_reset_edge_cnt", 32'(bus.o_edge_cnt), 6);
    checkOutput("pre_reset_bit_cnt", 32'(bus.o_bit_cnt), 3);
    checkOutput("pre_reset_valid", 32'(bus.o_sample_valid), 1);
    checkOutput("pre_reset_sampled", 32'(bus.o_sampled_bit), 0);
    i_reset = 1'b0;
    #1;
    checkReset("async_reset");
    tick();
    tick();
    checkReset("held_reset");
    i_reset = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
